// File: rtl/sys_pkg.sv
// Shared definitions for the PE_lin systolic array datapath.
//   ACC_W          default per-PE accumulator/result width
//   drain_state_t  state encoding of the drain stage
//   settle_cycles  fill/skew latency of one tile through the array; the
//                  drain stage and the upstream feeder must agree on it
package sys_pkg;

  localparam int ACC_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } drain_state_t;

  // Cycles from the start pulse until the last PE holds its final result:
  // the tile's inner length plus the row and column skew of the wavefront.
  function automatic int unsigned settle_cycles(input int unsigned k_len,
                                                input int unsigned rows,
                                                input int unsigned cols);
    return k_len + rows + cols - 1;
  endfunction

endpackage

// File: rtl/pe_drain.sv
// Drain stage behind the PE_lin systolic array.
// After a start pulse it waits out the array's settle latency, snapshots the
// whole ROWS x COLS result set into a shadow bank, and streams it out one row
// per valid/ready beat. The snapshot frees the array for the next tile while
// the previous one drains.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rstn       asynchronous active-low reset
//   start      one-cycle tile issue pulse (same cycle fire enters PE[0])
//   k_len      tile inner-dimension length, sampled with start
//   in_res     array results, element (i,j) at index j + i*COLS
//   busy       high while waiting for or draining a tile
//   out_valid  row beat valid
//   out_ready  consumer accepts the current beat
//   out_data   current row, element j = PE(row, j)
//   out_row    row index of the current beat
//   out_last   current beat is the final row
//   done       one-cycle pulse after the final row is accepted
module pe_drain #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ACC_W = sys_pkg::ACC_W,
  parameter int K_W   = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [K_W-1:0]                    k_len,
  input  logic [ACC_W*ROWS*COLS-1:0]        in_res,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_W*COLS-1:0]             out_data,
  output logic [$clog2(ROWS)-1:0]           out_row,
  output logic                              out_last,
  output logic                              done
);

  import sys_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int DW = ACC_W * COLS;
  // Wide enough for k_len + ROWS + COLS - 1 without truncation.
  localparam int SW = K_W + $clog2(ROWS + COLS) + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  drain_state_t  state;
  logic [SW-1:0] cnt;
  logic [SW-1:0] cnt_last;       // settle count minus one: the capture point
  logic [DW-1:0] bank [ROWS];
  logic [RW-1:0] next_row;

  assign next_row = out_row + 1'b1;

  // The capture point is latched as W-1 so WAIT only needs an equality test.
  function automatic logic [SW-1:0] capture_point(input logic [K_W-1:0] k);
    return SW'(settle_cycles(32'(k), ROWS, COLS) - 1);
  endfunction

  // NOTE: every register here, outputs included, is updated with non-blocking
  // assignments so all of them see the pre-edge value of out_row/out_last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      cnt_last  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      // NOTE: the shadow bank is small and its reset value is observable
      // (it must read as zero after reset), so it is reset like any register.
      for (int i = 0; i < ROWS; i++) bank[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT;
            cnt_last <= capture_point(k_len);
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end

        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == cnt_last) begin
            for (int i = 0; i < ROWS; i++) bank[i] <= in_res[i*DW +: DW];
            // Row 0 is loaded straight from the array so it is visible in the
            // cycle right after the capture edge.
            out_data  <= in_res[0 +: DW];
            out_row   <= '0;
            out_last  <= (ROWS == 1);
            out_valid <= 1'b1;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_row   <= '0;
              out_last  <= 1'b0;
              // A start on the final handshake chains straight into the next
              // tile; busy stays high across the boundary.
              if (start) begin
                state    <= WAIT;
                cnt_last <= capture_point(k_len);
                cnt      <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              out_row  <= next_row;
              out_data <= bank[next_row];
              out_last <= (next_row == LAST_ROW);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
